// File: rtl/serial_adder_scheduler_pkg.sv
// Shared types and the round-robin winner search used by the serial adder scheduler.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sas_state_t;

  // Upper bound on requesters the winner search can scan; callers zero-extend.
  localparam int MAX_NREQ = 64;

  // Returns the first valid index at or after ptr, wrapping modulo nreq.
  function automatic int rr_winner(input logic [MAX_NREQ-1:0] valid,
                                   input int ptr,
                                   input int nreq);
    int idx;
    rr_winner = ptr;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = (ptr + k) % nreq;
        if (valid[idx]) rr_winner = idx;
      end
    end
  endfunction

endpackage

// File: rtl/serial_adder_scheduler_if.sv
// Request and response channels between operand producers/result consumer and the scheduler.
interface serial_adder_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );
endinterface

// File: rtl/full_adder_cell_sva.sv
// Property checks for the shared full-adder cell, sampled on the scheduler clock.
module full_adder_cell_sva (
  input logic clk,
  input logic rst,
  input logic i_a,
  input logic i_b,
  input logic i_c,
  input logic i_sum,
  input logic i_carry
);
  a_fa_sum: assert property (@(posedge clk) disable iff (rst)
    i_sum == (i_a ^ i_b ^ i_c));

  a_fa_total: assert property (@(posedge clk) disable iff (rst)
    {i_carry, i_sum} == (2'(i_a) + 2'(i_b) + 2'(i_c)));
endmodule

// File: rtl/serial_adder_scheduler_full_adder_cell.sv
// The single 1-bit full-adder cell shared by all requesters.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder_scheduler.sv
// Round-robin scheduler that time-shares one full-adder cell to perform
// WIDTH-bit additions bit-serially, LSB first, with a valid/ready response.
module serial_adder_scheduler
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 2,
  localparam int IDW   = $clog2(NREQ)
) (
  input logic                    clk,
  input logic                    rst,
  serial_adder_scheduler_if.slave bus
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sas_state_t       r_state;
  sas_state_t       w_next_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_win;
  logic [CNTW-1:0]  r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             w_any_req;
  logic             w_fa_a;
  logic             w_fa_b;
  logic             w_fa_c;
  logic             w_fa_sum;
  logic             w_fa_carry;

  assign w_any_req = |bus.req_valid;
  assign w_win     = IDW'(rr_winner(MAX_NREQ'(bus.req_valid), int'(r_rr_ptr), NREQ));

  assign w_fa_a = r_a[0];
  assign w_fa_b = r_b[0];
  assign w_fa_c = r_carry;

  full_adder_cell u_fa (
    .i_a    (w_fa_a),
    .i_b    (w_fa_b),
    .i_c    (w_fa_c),
    .o_sum  (w_fa_sum),
    .o_carry(w_fa_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: next state is defaulted first so no branch leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = SHIFT;
      SHIFT:   if (r_cnt == CNTW'(WIDTH - 1)) w_next_state = DONE;
      DONE:    if (bus.rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_a      <= bus.req_a[w_win*WIDTH +: WIDTH];
            r_b      <= bus.req_b[w_win*WIDTH +: WIDTH];
            r_carry  <= bus.req_cin[w_win];
            r_id     <= w_win;
            r_cnt    <= '0;
            r_rr_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
          end
        end
        SHIFT: begin
          // Each sum bit enters at the MSB so the LSB-first stream ends up in place.
          r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_fa_carry;
          r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = '0;
    bus.rsp_sum   = '0;
    bus.rsp_cout  = 1'b0;
    bus.busy      = (r_state != IDLE);
    if (r_state == IDLE && w_any_req && !rst)
      bus.req_ready = NREQ'(1) << w_win;
    if (r_state == DONE) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = r_id;
      bus.rsp_sum   = r_sum;
      bus.rsp_cout  = r_carry;
    end
  end

endmodule

// File: doc/serial_adder_scheduler.md
Name: serial_adder_scheduler

Overview:
Shares one 1-bit full-adder cell between NREQ requesters by computing each requested WIDTH-bit addition bit-serially, LSB first. A round-robin arbiter selects one requester at a time. An FSM sequences the cell over WIDTH cycles using a carry register, then returns the result over a valid/ready response channel. It sits between operand producers and the shared adder cell, which has the same a/b/c/sum/carry function that our adder assertions check.

Parameters:
WIDTH, 8, operand width in bits; legal range ≥ 1.
NREQ, 2, number of requesters; legal range ≥ 2.
IDW, $clog2(NREQ), width of the requester ID.

Ports:
clk  in  1  clock; all flops rise-edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester accept; one-hot or zero.
req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
req_cin  in  NREQ  carry-in per requester.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accept.
rsp_id  out  IDW  index of the requester that is served.
rsp_sum  out  WIDTH  sum.
rsp_cout  out  1  carry-out.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is async and active-high. On reset:
  - state=IDLE, rr_ptr=0, bit counter=0, carry reg=0, shift regs=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
  - Reset mid-operation aborts the operation; no response is issued for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready is combinational. It is one-hot on the winner: the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … mod NREQ.
  - Handshake on a clock edge with req_valid[g] & req_ready[g]. On that edge:
    - latch A and B of requester g;
    - carry reg ← req_cin[g]; id ← g; counter ← 0;
    - rr_ptr ← (g+1) mod NREQ;
    - state → SHIFT.
  - If no req_valid is high, stay in IDLE and leave rr_ptr unchanged.
- SHIFT:
  - Each cycle the cell takes a=A[0], b=B[0], c=carry reg.
  - Each edge:
    - sum bit shifts into the MSB of the result register;
    - A and B shift right by 1;
    - carry reg ← cell carry; counter++.
  - When counter==WIDTH-1, the edge moves state → DONE. After the handshake edge, exactly WIDTH edges are spent in SHIFT.
- DONE:
  - rsp_valid=1; rsp_sum = result register; rsp_cout = carry reg.
  - All rsp_* outputs hold stable while rsp_ready=0.
  - An edge with rsp_ready=1 moves state → IDLE.
  - No request is accepted in DONE or SHIFT: req_ready=0.
- Latency: handshake at edge E0, rsp_valid visible after edge E_WIDTH. Minimum time between back-to-back accepts is WIDTH+2 cycles.
- Arithmetic: {rsp_cout, rsp_sum} = A + B + cin, modulo 2^(WIDTH+1). No overflow flag.
- Requests are not required to stay valid during SHIFT/DONE. Operands are sampled only at the handshake edge.
- If req_valid drops in IDLE before handshake, no grant is latched; the arbiter re-evaluates each cycle.
- rsp_ready high while rsp_valid is low has no effect.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sas_state_t;
  - a function that computes the round-robin winner index.
- Sub-module full_adder_cell (a, b, c → sum, carry) is the single shared datapath cell. It is instantiated once.
- Bind the existing full-adder property checks to full_adder_cell with clk.

Test Plan (WIDTH=8, NREQ=2):
1. Single request: req0 with A=0x5A, B=0x33, cin=0, rsp_ready=1 → rsp_valid after 8 edges; rsp_sum=0x8D, rsp_cout=0, rsp_id=0; busy high for 9 cycles.
2. Carry-chain wrap: req1 with A=0xFF, B=0x01, cin=1 → rsp_sum=0x01, rsp_cout=1, rsp_id=1.
3. Round-robin contention: both requesters held valid continuously after reset → grants alternate 0,1,0,1. Each req_ready pulse is one cycle and occurs only in IDLE.
4. Backpressure: rsp_ready=0 for 5 cycles in DONE → rsp_valid, rsp_sum and rsp_id stay stable; req_ready stays 0 even with req_valid=2'b11. Accept occurs one cycle after rsp_ready rises.
5. Reset mid-SHIFT: assert rst at bit 3 of A=0xAA, B=0x55 → all outputs 0 asynchronously and no rsp_valid. After release, a new req0 with A=0x01, B=0x01, cin=0 gives rsp_sum=0x02, and req0 is granted first (rr_ptr=0).
6. Random: 1000 random operand/valid/ready sequences → every response matches A+B+cin and the rr fairness bound (no requester waits more than NREQ-1 grants); the full_adder_cell assertions never fire.
